// File: rtl/btn_conditioner.sv
// Push-button front end: per-bit two-flop synchroniser, counter debounce, and
// one-cycle press / release / long-press events with a sticky long-press flag.
module btn_conditioner #(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int LONG_CYCLES     = 300000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] long_flag
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
        logic              meta;
        logic              sync;
        logic              level;
        logic              press;
        logic              rel;
        logic              lng;
        logic              flag;
        logic              accept;
        logic [DEB_W-1:0]  deb_cnt;
        logic [LONG_W-1:0] hold_cnt;

        // The synchronised value has disagreed with the stable level long enough.
        assign accept = (sync != level) && (deb_cnt == DEB_LAST);

        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values of the others, independent of statement order.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                meta <= 1'b0;
                sync <= 1'b0;
            end else begin
                meta <= btn_raw[i];
                sync <= meta;
            end
        end

        // NOTE: the counters are reset explicitly; an in-flight count must not
        // survive a reset, so they cannot be left to power-up values.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                level   <= 1'b0;
                deb_cnt <= '0;
                press   <= 1'b0;
                rel     <= 1'b0;
            end else begin
                press <= accept & sync;
                rel   <= accept & ~sync;
                if (sync == level) begin
                    deb_cnt <= '0;
                end else if (accept) begin
                    level   <= sync;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        // A release accepted on the same edge the hold count matures wins,
        // so a long event is never reported for a press that is ending.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_cnt <= '0;
                lng      <= 1'b0;
                flag     <= 1'b0;
            end else begin
                lng <= level && (hold_cnt == LONG_LAST) && !accept;
                if (!level) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != LONG_SAT) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                if (level && accept) begin
                    flag <= 1'b0;
                end else if (level && (hold_cnt == LONG_LAST)) begin
                    flag <= 1'b1;
                end
            end
        end

        assign btn_level[i]     = level;
        assign press_pulse[i]   = press;
        assign release_pulse[i] = rel;
        assign long_pulse[i]    = lng;
        assign long_flag[i]     = flag;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a behavioural model predicts every event
// cycle from the raw stimulus; a monitor matches DUT events against the queue.
module tb_btn_conditioner;

    localparam int NB   = 3;
    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse, long_flag;

    btn_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .long_flag    (long_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
        logic [NB-1:0] level;
        logic [NB-1:0] flag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: raw history two samples deep, stable level, length of the
    // current disagreement run, and how long the level has been high.
    bit m_d1[NB], m_d2[NB], m_lvl[NB], m_flag[NB];
    int m_run[NB], m_held[NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_flag[i] = 0;
            m_run[i] = 0; m_held[i] = 0;
        end
        exp_q.delete();
    endtask

    // One clock edge of the model, given the raw value present before the edge.
    task automatic model_step(input logic [NB-1:0] raw);
        exp_t e;
        bit   old_lvl, old_sync;
        cyc++;
        e.cyc = cyc; e.press = '0; e.rel = '0; e.lng = '0;
        for (int i = 0; i < NB; i++) begin
            old_lvl  = m_lvl[i];
            old_sync = m_d2[i];
            m_d2[i]  = m_d1[i];
            m_d1[i]  = raw[i];
            if (old_sync != old_lvl) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_run[i] = 0;
                    m_lvl[i] = old_sync;
                    if (old_sync) e.press[i] = 1'b1;
                    else          e.rel[i]   = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (old_lvl) begin
                m_held[i]++;
                if (m_held[i] == LONG && !e.rel[i]) begin
                    e.lng[i]  = 1'b1;
                    m_flag[i] = 1;
                end
            end else begin
                m_held[i] = 0;
            end
            if (e.rel[i]) m_flag[i] = 0;
        end
        for (int i = 0; i < NB; i++) begin
            e.level[i] = m_lvl[i];
            e.flag[i]  = m_flag[i];
        end
        if ((e.press | e.rel | e.lng) != '0) exp_q.push_back(e);
    endtask

    // Called at posedge+1; holds v on btn_raw for n edges.
    task automatic drive(input logic [NB-1:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk);
            model_step(v);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        model_clear();
        #1 check("async_reset_outputs",
                 {btn_level, press_pulse, release_pulse, long_pulse, long_flag}, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if ((press_pulse | release_pulse | long_pulse) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event",
                          {press_pulse, release_pulse, long_pulse}, '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", 64'(cyc), 64'(e.cyc));
                    check("event_outputs",
                          {press_pulse, release_pulse, long_pulse, btn_level, long_flag},
                          {e.press, e.rel, e.lng, e.level, e.flag});
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("missing_event",
                      {press_pulse, release_pulse, long_pulse}, {e.press, e.rel, e.lng});
            end
        end
    end

    initial begin
        reset   = 1'b0;
        btn_raw = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {btn_level, press_pulse, release_pulse, long_pulse, long_flag}, '0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Clean press of bit 0, released before the long threshold.
        drive(3'b001, 12);
        drive(3'b000, 12);
        // Bounce on bit 1: 1, 2 and 3 cycle glitches, then steady.
        drive(3'b010, 1);
        drive(3'b000, 2);
        drive(3'b010, 3);
        drive(3'b000, 1);
        drive(3'b010, 12);
        drive(3'b000, 12);
        // Long hold on bit 2, then release.
        drive(3'b100, 40);
        drive(3'b000, 12);
        // Short press: released ten cycles after its press event.
        drive(3'b001, 16);
        drive(3'b000, 12);
        // All bits at once.
        drive(3'b111, 12);
        drive(3'b000, 12);
        // Reset mid-hold with the button still down, then hold through long press.
        drive(3'b001, 14);
        pulse_reset();
        drive(3'b001, 30);
        drive(3'b000, 12);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            drive(3'($urandom_range(0, 7)), $urandom_range(1, 25));
        end

        drive(3'b000, 30);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
